// File: rtl/gcd_arbiter_pkg.sv
// gcd_arb_pkg
// Shared definitions for the GCD arbiter: the controller state encoding,
// default datapath/requester sizes and a helper for index widths.
// No ports; imported by rr_arbiter and gcd_arbiter.

package gcd_arb_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT,
    RESP
  } state_t;

  // Bits needed to hold an index 0..n-1 (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search starts one above the
// pointer (the last served requester) and wraps, so the pointer itself has
// the lowest priority.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index of the most recently served requester
//   grant out NUM_REQ  one-hot grant (all zero when nothing is requested)

module rr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Walk the requesters in rotated order ptr+1, ptr+2, ... ptr and grant
  // the first one that is asking; later matches are masked by 'found'.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Shares one external GCD engine between NUM_REQ requesters. A round-robin
// grant is taken in IDLE, the operands are latched, and the job is either
// answered directly (a zero operand) or sent to the engine. One job is in
// flight at a time; the result returns as a one-cycle pulse to the winner.
// Optional feature: define GCD_ARB_TIMEOUT_EN to add an engine watchdog that
// answers with rsp_err=1 and a zero result after TIMEOUT_CYCLES in WAIT.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_x/req_y per-requester request and packed operands
//                         (requester i uses bits [i*WIDTH +: WIDTH])
//   req_ready             one-hot accept pulse
//   rsp_valid             one-hot result pulse
//   rsp_result, rsp_err   shared result bus and timeout flag
//   eng_go/eng_x/eng_y    command to the external engine
//   eng_done/eng_out      engine completion and result
//   busy                  high whenever the controller is not in IDLE

module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     eng_go,
  output logic [WIDTH-1:0]         eng_x,
  output logic [WIDTH-1:0]         eng_y,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_out,
  output logic                     busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   sel_x;
  logic [WIDTH-1:0]   sel_y;
  logic               accept;
  logic               sel_zero;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant)
  );

  // Turn the one-hot grant into an index and pick the winner's operands.
  always_comb begin
    gnt_idx = '0;
    sel_x   = '0;
    sel_y   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = IDX_W'(i);
        sel_x   = req_x[i*WIDTH +: WIDTH];
        sel_y   = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst keeps req_ready low while reset is held, so nothing is
  // accepted in a cycle whose state update is being discarded.
  assign accept   = (state == IDLE) && (|req_valid) && !rst;
  assign sel_zero = (sel_x == '0) || (sel_y == '0);

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counts cycles spent in WAIT; it sits at zero elsewhere, so it always
  // starts from zero on entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A done arriving on the last allowed cycle still wins over the watchdog.
  assign timeout_hit = (state == WAIT) && !eng_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag for the job in flight: cleared on acceptance, set on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pulse outputs. GUARD exists only to skip one eng_done
  // sample, so a done still high from the previous job cannot complete
  // the new one.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    eng_go    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready = grant;
          state_nxt = sel_zero ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        eng_go    = 1'b1;
        state_nxt = GUARD;
      end
      GUARD: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_nxt        = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Job datapath: operands and winner latched on acceptance, result taken
  // either directly (x|y covers every zero-operand case, including 0,0) or
  // from the engine. The pointer moves to the winner once it is answered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        gnt_q <= gnt_idx;
        x_q   <= sel_x;
        y_q   <= sel_y;
        if (sel_zero) begin
          result_q <= sel_x | sel_y;
        end
      end
      if ((state == WAIT) && eng_done) begin
        result_q <= eng_out;
      end else if (timeout_hit) begin
        result_q <= '0;
      end
      if (state == RESP) begin
        ptr <= gnt_q;
      end
    end
  end

  assign eng_x      = x_q;
  assign eng_y      = y_q;
  assign rsp_result = result_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter
// Directed bench for gcd_arbiter with a behavioural GCD engine model.
// Build with GCD_ARB_TIMEOUT_EN defined to exercise the watchdog path;
// without it a long-latency job is checked to complete without error.

module tb_gcd_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_x = '0;
  logic [NUM_REQ*WIDTH-1:0] req_y = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_err;
  logic                     eng_go;
  logic [WIDTH-1:0]         eng_x;
  logic [WIDTH-1:0]         eng_y;
  logic                     eng_done = 1'b0;
  logic [WIDTH-1:0]         eng_out = '0;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;
  int go_count = 0;

  logic       hold_done = 1'b0;
  logic       eng_never = 1'b0;
  int         eng_lat   = 1;
  logic [7:0] eng_res   = '0;
  int         eng_cnt   = 0;
  logic       eng_stale = 1'b0;

  logic [7:0] rr_exp [4] = '{8'd6, 8'd7, 8'd25, 8'd1};

  gcd_arbiter #(
    .WIDTH         (WIDTH),
    .NUM_REQ       (NUM_REQ),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err),
    .eng_go    (eng_go),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_done  (eng_done),
    .eng_out   (eng_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference Euclid used by the engine model
  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Engine model: result eng_lat cycles after the go is seen. With
  // hold_done set, done stays high after completion and only drops one
  // cycle after the next go, i.e. it is still high during GUARD.
  always @(posedge clk) begin
    if (eng_go) begin
      eng_res   <= gcd_ref(eng_x, eng_y);
      eng_cnt   <= eng_never ? 0 : eng_lat;
      eng_stale <= hold_done;
      if (!hold_done) eng_done <= 1'b0;
    end else begin
      if (eng_stale) begin
        eng_stale <= 1'b0;
        eng_done  <= 1'b0;
      end
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_out  <= eng_res;
        eng_cnt  <= 0;
      end else if (eng_cnt > 1) begin
        eng_cnt <= eng_cnt - 1;
      end else if (!hold_done) begin
        eng_done <= 1'b0;
      end
    end
  end

  // Counts engine launches so tests can check how many go pulses occurred
  always @(posedge clk) begin
    if (eng_go) go_count <= go_count + 1;
  end

  // Hard time bound so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [7:0] x, input logic [7:0] y);
    req_valid[idx]            = v;
    req_x[idx*WIDTH +: WIDTH] = x;
    req_y[idx*WIDTH +: WIDTH] = y;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Ticks until any rsp_valid bit is high or the budget runs out
  task automatic waitRsp(input int start, input int max, output int cycles);
    cycles = start;
    while ((rsp_valid == '0) && (cycles < max)) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int g;
    int go0;
    int cyc;

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_eng_go", eng_go, 0);
    checkOutput("rst_rsp_result", rsp_result, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_eng_x", eng_x, 0);
    checkOutput("rst_eng_y", eng_y, 0);
    applyStimulus(1, 1'b1, 8'd3, 8'd6);
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    applyStimulus(1, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    tick();

    // ---------------- single request 12,18 ----------------
    $display("[TB] single request");
    go0 = go_count;
    applyStimulus(0, 1'b1, 8'd12, 8'd18);
    #1;
    checkOutput("single_ready", req_ready, 32'h1);
    tick();
    applyStimulus(0, 1'b0, 8'd0, 8'd0);
    #1;
    checkOutput("single_ready_pulse", req_ready, 0);
    checkOutput("single_go", eng_go, 1);
    checkOutput("single_eng_x", eng_x, 12);
    checkOutput("single_eng_y", eng_y, 18);
    checkOutput("single_busy", busy, 1);
    tick();
    checkOutput("single_go_low", eng_go, 0);
    tick();
    checkOutput("single_wait_x", eng_x, 12);
    checkOutput("single_no_early_rsp", rsp_valid, 0);
    tick();
    checkOutput("single_rsp_valid", rsp_valid, 32'h1);
    checkOutput("single_result", rsp_result, 6);
    checkOutput("single_err", rsp_err, 0);
    tick();
    checkOutput("single_rsp_pulse", rsp_valid, 0);
    checkOutput("single_idle", busy, 0);
    checkOutput("single_go_count", go_count - go0, 1);

    // ---------------- round robin, all four held ----------------
    $display("[TB] round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'd12, 8'd18);
    applyStimulus(1, 1'b1, 8'd35, 8'd14);
    applyStimulus(2, 1'b1, 8'd100, 8'd75);
    applyStimulus(3, 1'b1, 8'd17, 8'd5);
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      checkOutput($sformatf("rr_ready_%0d", k), req_ready, 32'(1) << g);
      tick();
      tick();
      tick();
      tick();
      checkOutput($sformatf("rr_rsp_%0d", k), rsp_valid, 32'(1) << g);
      checkOutput($sformatf("rr_result_%0d", k), rsp_result, rr_exp[g]);
      tick();
    end
    req_valid = '0;
    #1;
    checkOutput("rr_no_accept", req_ready, 0);
    tick();
    checkOutput("rr_idle", busy, 0);

    // ---------------- zero operands from requester 2 ----------------
    $display("[TB] zero operands");
    go0 = go_count;
    applyStimulus(2, 1'b1, 8'd0, 8'd9);
    #1;
    checkOutput("zero_ready_a", req_ready, 32'h4);
    tick();
    applyStimulus(2, 1'b0, 8'd0, 8'd0);
    #1;
    checkOutput("zero_rsp_a", rsp_valid, 32'h4);
    checkOutput("zero_result_a", rsp_result, 9);
    checkOutput("zero_go_a", eng_go, 0);
    tick();
    applyStimulus(2, 1'b1, 8'd0, 8'd0);
    #1;
    checkOutput("zero_ready_b", req_ready, 32'h4);
    tick();
    applyStimulus(2, 1'b0, 8'd0, 8'd0);
    #1;
    checkOutput("zero_rsp_b", rsp_valid, 32'h4);
    checkOutput("zero_result_b", rsp_result, 0);
    tick();
    checkOutput("zero_go_count", go_count - go0, 0);
    checkOutput("zero_idle", busy, 0);

    // ---------------- stale done held across a new go ----------------
    $display("[TB] stale done");
    hold_done = 1'b1;
    eng_lat   = 1;
    applyStimulus(1, 1'b1, 8'd21, 8'd14);
    #1;
    checkOutput("stale_ready_a", req_ready, 32'h2);
    tick();
    applyStimulus(1, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    tick();
    checkOutput("stale_rsp_a", rsp_valid, 32'h2);
    checkOutput("stale_result_a", rsp_result, 7);
    tick();
    tick();
    eng_lat = 3;
    applyStimulus(3, 1'b1, 8'd48, 8'd36);
    #1;
    checkOutput("stale_ready_b", req_ready, 32'h8);
    tick();
    applyStimulus(3, 1'b0, 8'd0, 8'd0);
    #1;
    checkOutput("stale_go_b", eng_go, 1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("stale_no_early_%0d", k), rsp_valid, 0);
    end
    tick();
    checkOutput("stale_rsp_b", rsp_valid, 32'h8);
    checkOutput("stale_result_b", rsp_result, 12);
    hold_done = 1'b0;
    eng_lat   = 1;
    tick();

`ifdef GCD_ARB_TIMEOUT_EN
    // ---------------- watchdog: engine never finishes ----------------
    $display("[TB] watchdog timeout");
    eng_never = 1'b1;
    applyStimulus(0, 1'b1, 8'd30, 8'd45);
    #1;
    checkOutput("to_ready", req_ready, 32'h1);
    tick();
    applyStimulus(0, 1'b0, 8'd0, 8'd0);
    waitRsp(1, 60, cyc);
    checkOutput("to_latency", cyc, 19);
    checkOutput("to_rsp", rsp_valid, 32'h1);
    checkOutput("to_err", rsp_err, 1);
    checkOutput("to_result", rsp_result, 0);
    tick();
    eng_never = 1'b0;
    applyStimulus(1, 1'b1, 8'd8, 8'd12);
    #1;
    checkOutput("to_next_ready", req_ready, 32'h2);
    tick();
    applyStimulus(1, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    tick();
    checkOutput("to_next_rsp", rsp_valid, 32'h2);
    checkOutput("to_next_result", rsp_result, 4);
    checkOutput("to_next_err", rsp_err, 0);
    tick();
`else
    // ---------------- long engine latency, no watchdog ----------------
    $display("[TB] long latency");
    eng_lat = 40;
    applyStimulus(0, 1'b1, 8'd30, 8'd45);
    #1;
    checkOutput("long_ready", req_ready, 32'h1);
    tick();
    applyStimulus(0, 1'b0, 8'd0, 8'd0);
    waitRsp(1, 80, cyc);
    checkOutput("long_latency", cyc, 43);
    checkOutput("long_rsp", rsp_valid, 32'h1);
    checkOutput("long_result", rsp_result, 15);
    checkOutput("long_err", rsp_err, 0);
    eng_lat = 1;
    tick();
`endif

    // ---------------- reset while waiting on the engine ----------------
    $display("[TB] reset mid-job");
    eng_lat = 5;
    applyStimulus(3, 1'b1, 8'd10, 8'd4);
    #1;
    checkOutput("mid_ready", req_ready, 32'h8);
    tick();
    applyStimulus(3, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_go", eng_go, 0);
    checkOutput("mid_rsp", rsp_valid, 0);
    for (int k = 5; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("mid_no_rsp_%0d", k), rsp_valid, 0);
    end
    tick();
    eng_lat = 1;
    applyStimulus(0, 1'b1, 8'd12, 8'd8);
    applyStimulus(1, 1'b1, 8'd9, 8'd3);
    applyStimulus(2, 1'b1, 8'd5, 8'd5);
    applyStimulus(3, 1'b1, 8'd7, 8'd7);
    #1;
    checkOutput("mid_next_ready", req_ready, 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    checkOutput("mid_next_rsp", rsp_valid, 32'h1);
    checkOutput("mid_next_result", rsp_result, 4);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4: number of requester ports, 2..16.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: engine watchdog limit in cycles; used only with GCD_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic samples on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester request; held until accepted.
REQ-007 req_x, req_y  in  NUM_REQ x WIDTH  per-requester operands.
REQ-008 req_ready  out  NUM_REQ  one-hot accept pulse.
REQ-009 rsp_valid  out  NUM_REQ  one-hot result pulse to the granted requester.
REQ-010 rsp_result  out  WIDTH  shared result bus, valid while any rsp_valid bit is high.
REQ-011 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-012 eng_go, eng_x, eng_y  out  1/WIDTH/WIDTH  command to the shared GCD engine.
REQ-013 eng_done, eng_out  in  1/WIDTH  engine completion and result.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, GUARD, WAIT and RESP.
REQ-016 IDLE, any req_valid high: grant round-robin, searching from ptr+1 upward and wrapping at NUM_REQ; pulse req_ready[g] for that cycle; latch x, y and g.
REQ-017 Latched x==0 or y==0: skip the engine, set result = x|y (gcd(0,0)=0), go to RESP.
REQ-018 Otherwise go to LAUNCH; drive eng_go=1 for exactly one cycle with eng_x/eng_y = latched operands; go to GUARD.
REQ-019 GUARD lasts one cycle with eng_done ignored, so a stale done from the previous job is never taken; then WAIT.
REQ-020 WAIT: on eng_done=1, register eng_out into result and go to RESP.
REQ-021 RESP: rsp_valid[g]=1 for exactly one cycle with rsp_result and rsp_err; set ptr=g; go to IDLE.
REQ-022 Latency from acceptance cycle T: eng_go high in T+1, first done sample in T+3, rsp_valid in the cycle after done is sampled; zero-operand jobs give rsp_valid in T+1.
REQ-023 There is no response backpressure; a requester SHALL be able to re-request in the cycle after its rsp_valid.
REQ-024 req_valid changes outside IDLE SHALL be ignored; at most one job is in flight.
REQ-025 eng_x/eng_y SHALL hold the latched operands from LAUNCH through WAIT.
REQ-026 Outside LAUNCH, eng_go SHALL be 0.

Reset
REQ-027 On rst: state=IDLE, ptr=NUM_REQ-1 so requester 0 wins first; all outputs 0; result=0.
REQ-028 rst mid-job SHALL abandon the job with no rsp_valid; eng_go is 0 from the next cycle.

Configuration
REQ-029 The macro GCD_ARB_TIMEOUT_EN enables the watchdog.
REQ-030 With GCD_ARB_TIMEOUT_EN defined: a cycle counter is cleared on entering WAIT; if TIMEOUT_CYCLES elapse without eng_done, go to RESP with rsp_err=1 and rsp_result=0.
REQ-031 Without GCD_ARB_TIMEOUT_EN: no counter; WAIT persists until eng_done; rsp_err is tied to 0.

Structure
REQ-032 The package gcd_arb_pkg SHALL hold the state enum typedef and the default WIDTH and NUM_REQ constants.
REQ-033 Round-robin grant selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant).
REQ-034 The GCD engine is external and connected only through the eng_* ports.

Verification
REQ-035 Single request: requester 0 sends 12,18 -> one-cycle req_ready[0]; eng_go one cycle; rsp_valid[0] with rsp_result=6, rsp_err=0.
REQ-036 All four requesters hold valid continuously after reset -> grants in order 0,1,2,3,0; each gets exactly one rsp_valid per grant.
REQ-037 Requester 2 sends 0,9, then 0,0 -> rsp_result 9, then 0, each rsp_valid in T+1; eng_go never asserts.
REQ-038 Model engine holds eng_done high from the prior job at the new eng_go -> no early RESP; the result comes from the new done.
REQ-039 With GCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never signals done -> rsp_valid with rsp_err=1 and rsp_result=0; the next request is then served normally.
REQ-040 rst asserted in WAIT -> no rsp_valid; busy=0 the next cycle; the next grant goes to requester 0.
